// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared encodings for the memory-port arbiter: FSM state, transaction
//   owner, and the fixed size code used for instruction fetches.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_t;

   // Fetches are always full-word reads.
   localparam logic [2:0] MEMOP_WORD = 3'b010;

   // Latency counter width; LATENCY is limited to 1..15.
   localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_rr2.sv
// mem_arb_rr2
//   Two-way round-robin grant picker. A lone requester is granted; on a tie
//   the requester that did not win last time is granted. last_grant only
//   moves when i_update is high (i.e. the grant was actually taken).
// Ports:
//   clk, rst        clock, synchronous active-high reset (last_grant := LSU)
//   i_req_ifu/lsu   qualified request lines
//   i_update        a grant was consumed this cycle; record the winner
//   o_gnt_ifu/lsu   one-hot (or zero) combinational grant
module mem_arb_rr2
   import mem_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_req_ifu,
   input  logic i_req_lsu,
   input  logic i_update,
   output logic o_gnt_ifu,
   output logic o_gnt_lsu
);

   owner_t r_last;

   // Reset to LSU so the IFU wins the first tie.
   always_ff @(posedge clk) begin
      if (rst)
         r_last <= OWN_LSU;
      else if (i_update)
         r_last <= o_gnt_lsu ? OWN_LSU : OWN_IFU;
   end

   always_comb begin
      o_gnt_ifu = i_req_ifu && (!i_req_lsu || (r_last == OWN_LSU));
      o_gnt_lsu = i_req_lsu && !o_gnt_ifu;
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory port between instruction fetch (read-only) and
//   load/store. One transaction at a time: IDLE arbitrates and latches the
//   request, ACCESS waits LATENCY cycles and strobes ren/wen in its last
//   cycle, RESP holds the response until the owner takes it.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ifu_req_* / ifu_addr          fetch request (valid/ready)
//   ifu_resp_* / ifu_rdata        fetch response (valid/ready)
//   lsu_req_* / lsu_wen/addr/wdata/mem_op   load/store request
//   lsu_resp_* / lsu_rdata        load data or store completion (rdata 0)
//   mem_ren/raddr, mem_wen/waddr/wdata, mem_mem_op   memory port outputs
//   mem_rdata                     combinational read data from memory
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LATENCY    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ifu_req_valid,
   output logic                  ifu_req_ready,
   input  logic [ADDR_WIDTH-1:0] ifu_addr,
   output logic                  ifu_resp_valid,
   input  logic                  ifu_resp_ready,
   output logic [DATA_WIDTH-1:0] ifu_rdata,
   input  logic                  lsu_req_valid,
   output logic                  lsu_req_ready,
   input  logic                  lsu_wen,
   input  logic [ADDR_WIDTH-1:0] lsu_addr,
   input  logic [DATA_WIDTH-1:0] lsu_wdata,
   input  logic [2:0]            lsu_mem_op,
   output logic                  lsu_resp_valid,
   input  logic                  lsu_resp_ready,
   output logic [DATA_WIDTH-1:0] lsu_rdata,
   output logic                  mem_ren,
   output logic [ADDR_WIDTH-1:0] mem_raddr,
   output logic                  mem_wen,
   output logic [ADDR_WIDTH-1:0] mem_waddr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [2:0]            mem_mem_op,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   owner_t                r_owner;
   logic [CNT_W-1:0]      r_cnt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_wen;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [2:0]            r_op;
   logic [DATA_WIDTH-1:0] r_rdata;

   logic w_idle;
   logic w_gnt_ifu;
   logic w_gnt_lsu;
   logic w_hs;
   logic w_strobe;
   logic w_resp_hs;

   assign w_idle = (r_state == IDLE);

   // Requests are only visible to the picker in IDLE, so grants (and hence
   // req_ready) are zero in every other state.
   mem_arb_rr2 u_rr (
      .clk       (clk),
      .rst       (rst),
      .i_req_ifu (w_idle && ifu_req_valid),
      .i_req_lsu (w_idle && lsu_req_valid),
      .i_update  (w_hs),
      .o_gnt_ifu (w_gnt_ifu),
      .o_gnt_lsu (w_gnt_lsu)
   );

   // A grant already implies valid, so grant == handshake.
   assign w_hs      = w_gnt_ifu || w_gnt_lsu;
   // Last ACCESS cycle: the single cycle that pulses ren/wen.
   assign w_strobe  = (r_state == ACCESS) && (r_cnt == '0);
   assign w_resp_hs = (r_state == RESP) &&
                      ((r_owner == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready);

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt    = r_state;
      ifu_req_ready  = w_gnt_ifu;
      lsu_req_ready  = w_gnt_lsu;
      ifu_resp_valid = 1'b0;
      ifu_rdata      = '0;
      lsu_resp_valid = 1'b0;
      lsu_rdata      = '0;
      mem_ren        = 1'b0;
      mem_raddr      = '0;
      mem_wen        = 1'b0;
      mem_waddr      = '0;
      mem_wdata      = '0;
      mem_mem_op     = '0;
      case (r_state)
         IDLE: begin
            if (w_hs)
               w_state_nxt = ACCESS;
         end
         ACCESS: begin
            mem_raddr  = r_addr;
            mem_waddr  = r_addr;
            mem_wdata  = r_wdata;
            mem_mem_op = r_op;
            mem_ren    = w_strobe && !r_wen;
            mem_wen    = w_strobe && r_wen;
            if (w_strobe)
               w_state_nxt = RESP;
         end
         RESP: begin
            if (r_owner == OWN_LSU) begin
               lsu_resp_valid = 1'b1;
               lsu_rdata      = r_rdata;
            end else begin
               ifu_resp_valid = 1'b1;
               ifu_rdata      = r_rdata;
            end
            if (w_resp_hs)
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Request latch, latency counter and response capture. Reset drops any
   // in-flight transaction before its strobe cycle, so no late wen can leak.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner <= OWN_IFU;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wen   <= 1'b0;
         r_wdata <= '0;
         r_op    <= '0;
         r_rdata <= '0;
      end else if (w_hs) begin
         r_cnt <= CNT_LOAD;
         if (w_gnt_lsu) begin
            r_owner <= OWN_LSU;
            r_addr  <= lsu_addr;
            r_wen   <= lsu_wen;
            r_wdata <= lsu_wdata;
            r_op    <= lsu_mem_op;
         end else begin
            r_owner <= OWN_IFU;
            r_addr  <= ifu_addr;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_op    <= MEMOP_WORD;
         end
      end else if (r_state == ACCESS) begin
         if (w_strobe)
            r_rdata <= r_wen ? '0 : mem_rdata;
         else
            r_cnt <= r_cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int NI = 4;

   function automatic int lat_of(input int k);
      case (k)
         0: return 1;
         1: return 3;
         2: return 4;
         default: return 15;
      endcase
   endfunction

   // Memory contents seen by the arbiter (address-keyed constants).
   function automatic logic [31:0] memval(input logic [31:0] a);
      if (a == 32'h8000_0000) return 32'h0000_0413;
      if (a == 32'h8000_2000) return 32'h1234_5678;
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic        ifu_req_valid [NI], ifu_req_ready [NI], ifu_resp_valid [NI], ifu_resp_ready [NI];
   logic        lsu_req_valid [NI], lsu_req_ready [NI], lsu_wen [NI], lsu_resp_valid [NI], lsu_resp_ready [NI];
   logic        mem_ren [NI], mem_wen [NI];
   logic [31:0] ifu_addr [NI], ifu_rdata [NI], lsu_addr [NI], lsu_wdata [NI], lsu_rdata [NI];
   logic [31:0] mem_raddr [NI], mem_waddr [NI], mem_wdata [NI], mem_rdata [NI];
   logic [2:0]  lsu_mem_op [NI], mem_mem_op [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      // Garbage when not reading, so a capture in the wrong cycle shows up.
      assign mem_rdata[g] = mem_ren[g] ? memval(mem_raddr[g]) : (32'hBAD0_0000 | 32'(cyc));
      mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LATENCY(lat_of(g))) u_dut (
         .clk            (clk),
         .rst            (rst),
         .ifu_req_valid  (ifu_req_valid[g]),
         .ifu_req_ready  (ifu_req_ready[g]),
         .ifu_addr       (ifu_addr[g]),
         .ifu_resp_valid (ifu_resp_valid[g]),
         .ifu_resp_ready (ifu_resp_ready[g]),
         .ifu_rdata      (ifu_rdata[g]),
         .lsu_req_valid  (lsu_req_valid[g]),
         .lsu_req_ready  (lsu_req_ready[g]),
         .lsu_wen        (lsu_wen[g]),
         .lsu_addr       (lsu_addr[g]),
         .lsu_wdata      (lsu_wdata[g]),
         .lsu_mem_op     (lsu_mem_op[g]),
         .lsu_resp_valid (lsu_resp_valid[g]),
         .lsu_resp_ready (lsu_resp_ready[g]),
         .lsu_rdata      (lsu_rdata[g]),
         .mem_ren        (mem_ren[g]),
         .mem_raddr      (mem_raddr[g]),
         .mem_wen        (mem_wen[g]),
         .mem_waddr      (mem_waddr[g]),
         .mem_wdata      (mem_wdata[g]),
         .mem_mem_op     (mem_mem_op[g]),
         .mem_rdata      (mem_rdata[g])
      );
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Transaction-level reference: one outstanding transaction, its age in
   // cycles since the handshake, and who won the previous arbitration.
   bit          m_busy, m_own, m_wen, m_last;
   int          m_t;
   logic [31:0] m_addr, m_wdata, m_exp;
   logic [2:0]  m_op;
   bit          hs_i, hs_l, rhs;
   bit          o_ir, o_lr, o_iv, o_lv;
   int          wen_pulses;

   task automatic step(input int k, input bit do_chk);
      int lat;
      bit e_ir, e_lr, e_ren, e_wen, e_iv, e_lv;
      logic [31:0] e_ra, e_wa, e_wd, e_ird, e_lrd;
      logic [2:0]  e_op;
      lat = lat_of(k);
      {e_ir, e_lr, e_ren, e_wen, e_iv, e_lv} = '0;
      e_ra = '0; e_wa = '0; e_wd = '0; e_ird = '0; e_lrd = '0; e_op = '0;
      if (!m_busy) begin
         e_ir = ifu_req_valid[k] && (!lsu_req_valid[k] || m_last);
         e_lr = lsu_req_valid[k] && !e_ir;
      end else if (m_t <= lat) begin
         e_ra = m_addr; e_wa = m_addr; e_wd = m_wdata; e_op = m_op;
         e_ren = (m_t == lat) && !m_wen;
         e_wen = (m_t == lat) && m_wen;
      end else begin
         e_iv = !m_own;
         e_lv = m_own;
         if (m_own) e_lrd = m_exp; else e_ird = m_exp;
      end
      @(negedge clk);
      o_ir = ifu_req_ready[k]; o_lr = lsu_req_ready[k];
      o_iv = ifu_resp_valid[k]; o_lv = lsu_resp_valid[k];
      if (mem_wen[k] === 1'b1) wen_pulses++;
      if (do_chk) begin
         chk("req_ready",  {ifu_req_ready[k], lsu_req_ready[k]}, {e_ir, e_lr});
         chk("mem_strobe", {mem_ren[k], mem_wen[k]}, {e_ren, e_wen});
         chk("mem_raddr",  mem_raddr[k], e_ra);
         chk("mem_waddr",  mem_waddr[k], e_wa);
         chk("mem_wdata",  mem_wdata[k], e_wd);
         chk("mem_op",     mem_mem_op[k], e_op);
         chk("resp_valid", {ifu_resp_valid[k], lsu_resp_valid[k]}, {e_iv, e_lv});
         chk("ifu_rdata",  ifu_rdata[k], e_ird);
         chk("lsu_rdata",  lsu_rdata[k], e_lrd);
      end
      @(posedge clk);
      #1;
      hs_i = 0; hs_l = 0; rhs = 0;
      if (rst) begin
         m_busy = 0; m_last = 1;
      end else if (!m_busy) begin
         if (e_ir) begin
            hs_i = 1; m_busy = 1; m_t = 1; m_own = 0; m_last = 0;
            m_addr = ifu_addr[k]; m_wen = 0; m_wdata = '0; m_op = 3'b010;
            m_exp = memval(ifu_addr[k]);
         end else if (e_lr) begin
            hs_l = 1; m_busy = 1; m_t = 1; m_own = 1; m_last = 1;
            m_addr = lsu_addr[k]; m_wen = lsu_wen[k]; m_wdata = lsu_wdata[k];
            m_op = lsu_mem_op[k];
            m_exp = lsu_wen[k] ? 32'h0 : memval(lsu_addr[k]);
         end
      end else if (m_t <= lat) begin
         m_t++;
      end else if (m_own ? lsu_resp_ready[k] : ifu_resp_ready[k]) begin
         rhs = 1; m_busy = 0;
      end
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < NI; i++) begin
         ifu_req_valid[i] = 0; ifu_addr[i] = '0; ifu_resp_ready[i] = 0;
         lsu_req_valid[i] = 0; lsu_wen[i] = 0; lsu_addr[i] = '0;
         lsu_wdata[i] = '0; lsu_mem_op[i] = '0; lsu_resp_ready[i] = 0;
      end
   endtask

   task automatic do_reset(input int k);
      clear_inputs();
      rst = 1;
      step(k, 0);
      step(k, 0);
      rst = 0;
      step(k, 1);
   endtask

   // Issue one request, then hold resp_ready low for `hold` response cycles.
   task automatic do_req(input int k, input bit is_lsu, input bit wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] op, input int hold);
      bit got;
      int seen;
      if (is_lsu) begin
         lsu_req_valid[k] = 1; lsu_wen[k] = wen; lsu_addr[k] = addr;
         lsu_wdata[k] = wdata; lsu_mem_op[k] = op;
      end else begin
         ifu_req_valid[k] = 1; ifu_addr[k] = addr;
      end
      got = 0;
      for (int n = 0; n < 20 && !got; n++) begin
         step(k, 1);
         got = is_lsu ? hs_l : hs_i;
      end
      if (is_lsu) lsu_req_valid[k] = 0; else ifu_req_valid[k] = 0;
      if (!got) begin
         chk("accept_timeout", 0, 1);
         return;
      end
      got = 0; seen = 0;
      for (int n = 1; n <= 40 && !got; n++) begin
         ifu_resp_ready[k] = (seen >= hold);
         lsu_resp_ready[k] = (seen >= hold);
         step(k, 1);
         if (o_iv || o_lv) begin
            if (seen == 0) chk("resp_latency", n, lat_of(k) + 1);
            seen++;
         end
         got = rhs;
      end
      ifu_resp_ready[k] = 0; lsu_resp_ready[k] = 0;
      if (!got) chk("resp_timeout", 0, 1);
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(3))
         0: return 32'h8000_0000;
         1: return 32'h8000_2000;
         default: return $urandom;
      endcase
   endfunction

   task automatic run_random(input int k, input int ncyc);
      bit pend_i, pend_l;
      do_reset(k);
      for (int n = 0; n < ncyc; n++) begin
         pend_i = ifu_req_valid[k] && !hs_i;
         pend_l = lsu_req_valid[k] && !hs_l;
         if (!pend_i || $urandom_range(9) == 0) begin
            ifu_req_valid[k] = ($urandom_range(99) < 50);
            ifu_addr[k] = rand_addr();
         end
         if (!pend_l || $urandom_range(9) == 0) begin
            lsu_req_valid[k] = ($urandom_range(99) < 50);
            lsu_wen[k] = $urandom_range(1);
            lsu_addr[k] = rand_addr();
            lsu_wdata[k] = $urandom;
            lsu_mem_op[k] = 3'($urandom_range(7));
         end
         ifu_resp_ready[k] = $urandom_range(1);
         lsu_resp_ready[k] = $urandom_range(1);
         rst = ($urandom_range(299) == 0);
         step(k, 1);
      end
      rst = 0;
      clear_inputs();
   endtask

   initial begin
      int gcount;
      bit got;
      clear_inputs();

      // Fetch, LATENCY=1.
      do_reset(0);
      do_req(0, 0, 0, 32'h8000_0000, '0, '0, 0);

      // Four back-to-back ties alternate IFU, LSU, IFU, LSU.
      do_reset(0);
      ifu_req_valid[0] = 1; ifu_addr[0] = 32'h8000_0100;
      lsu_req_valid[0] = 1; lsu_wen[0] = 0; lsu_addr[0] = 32'h8000_2000; lsu_mem_op[0] = 3'b100;
      ifu_resp_ready[0] = 1; lsu_resp_ready[0] = 1;
      gcount = 0;
      for (int n = 0; n < 60 && gcount < 4; n++) begin
         step(0, 1);
         if (o_ir || o_lr) begin
            chk("grant_order", o_lr, 64'(gcount % 2));
            gcount++;
         end
      end
      if (gcount < 4) chk("grant_timeout", 0, 1);
      ifu_req_valid[0] = 0; lsu_req_valid[0] = 0;
      for (int n = 0; n < 6; n++) step(0, 1);

      // Store, LATENCY=3: single wen pulse, rdata 0.
      do_reset(1);
      wen_pulses = 0;
      do_req(1, 1, 1, 32'h8000_1000, 32'hDEAD_BEEF, 3'b010, 0);
      chk("store_wen_pulses", wen_pulses, 1);

      // Load held in RESP for 5 cycles while IFU waits, which must not be granted.
      do_req(1, 0, 0, 32'h8000_0040, '0, '0, 0);
      ifu_req_valid[1] = 1; ifu_addr[1] = 32'h8000_0080;
      do_req(1, 1, 0, 32'h8000_2000, 32'h0000_0001, 3'b010, 5);
      ifu_resp_ready[1] = 1;
      step(1, 1);
      ifu_req_valid[1] = 0;
      for (int n = 0; n < 8; n++) step(1, 1);
      ifu_resp_ready[1] = 0;

      // Reset in the 2nd ACCESS cycle of a store, LATENCY=4.
      do_reset(2);
      lsu_req_valid[2] = 1; lsu_wen[2] = 1; lsu_addr[2] = 32'h8000_3000;
      lsu_wdata[2] = 32'hCAFE_F00D; lsu_mem_op[2] = 3'b001;
      got = 0;
      for (int n = 0; n < 10 && !got; n++) begin
         step(2, 1);
         got = hs_l;
      end
      if (!got) chk("accept_timeout", 0, 1);
      lsu_req_valid[2] = 0;
      wen_pulses = 0;
      step(2, 1);
      rst = 1;
      step(2, 1);
      rst = 0;
      for (int n = 0; n < 6; n++) step(2, 1);
      chk("rst_no_wen", wen_pulses, 0);
      do_req(2, 0, 0, 32'h8000_0000, '0, '0, 0);

      // LATENCY=15 load: response 16 cycles after handshake.
      do_reset(3);
      do_req(3, 1, 0, 32'h8000_0000, '0, 3'b010, 0);

      for (int k = 0; k < NI; k++) run_random(k, 400);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
